// File: rtl/mips_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU with a stream handshake; one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: trivial operations (divisor zero, |dividend| < |divisor|) finish one cycle after accept.
module mips_iter_divider #(
  parameter int SIGNED = 1,
  parameter int WIDTH  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  // state  | meaning
  // S_IDLE | ready, waiting for both operands
  // S_CALC | iterating one quotient bit per clock
  // S_DONE | result pulse on dout
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nx;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH:0]     r_dvs;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_dvd_raw;
  logic               r_dvd_neg;
  logic               r_dvs_neg;
  logic               r_early;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_dout;

  logic               w_accept;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_abs;
  logic [WIDTH-1:0]   w_dvs_abs;
  logic               w_early;
  logic               w_last;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH:0]     w_rem_nx;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [2*WIDTH-1:0] w_result;

  assign w_accept  = (r_state == S_IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid && !flush;
  assign w_dvd_neg = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
  assign w_dvs_neg = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
  // A WIDTH-bit unsigned magnitude holds even the most negative operand exactly.
  assign w_dvd_abs = w_dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign w_dvs_abs = w_dvs_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (s_axis_divisor_tdata == '0) || (w_dvd_abs < w_dvs_abs);
`else
  assign w_early = 1'b0;
`endif

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_rem_sh = (r_rem << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};
  assign w_diff   = w_rem_sh - r_dvs;
  assign w_qbit   = (w_rem_sh >= r_dvs);
  assign w_rem_nx = w_qbit ? w_diff : w_rem_sh;
  assign w_q_mag  = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_q_fix  = (r_dvd_neg ^ r_dvs_neg) ? -w_q_mag : w_q_mag;
  assign w_r_fix  = r_dvd_neg ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];

  always_comb begin
    w_result = {w_q_fix, w_r_fix};
    if (r_dvs == '0)
      w_result = {{WIDTH{1'b1}}, r_dvd_raw};
    else if (r_early)
      w_result = {{WIDTH{1'b0}}, r_dvd_raw};
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_CALC;
      S_CALC:  if (r_early || w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush)
      w_state_nx = S_IDLE;
  end

  always_comb begin
    s_axis_divisor_tready  = (r_state == S_IDLE);
    s_axis_dividend_tready = (r_state == S_IDLE);
    m_axis_dout_tvalid     = (r_state == S_DONE);
  end

  // The quotient bits shift into r_dvd from the bottom as the dividend bits leave the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_dvd_raw <= '0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_early   <= 1'b0;
      r_cnt     <= '0;
      r_dout    <= '0;
    end else if (w_accept) begin
      r_dvd     <= w_dvd_abs;
      r_dvs     <= {1'b0, w_dvs_abs};
      r_rem     <= '0;
      r_dvd_raw <= s_axis_dividend_tdata;
      r_dvd_neg <= w_dvd_neg;
      r_dvs_neg <= w_dvs_neg;
      r_early   <= w_early;
      r_cnt     <= '0;
    end else if (r_state == S_CALC) begin
      r_dvd <= w_q_mag;
      r_rem <= w_rem_nx;
      r_cnt <= r_cnt + CW'(1);
      if (!flush && (r_early || w_last))
        r_dout <= w_result;
    end
  end

  assign m_axis_dout_tdata = r_dout;

endmodule

// File: tb/tb_mips_iter_divider.sv
// Self-checking bench: a signed and an unsigned divider share stimulus and are compared
// against plain-arithmetic reference division.
module tb_mips_iter_divider;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        dvs_v, dvd_v;
  logic [31:0] dvs_d, dvd_d;
  logic        s_rdy_dvs, s_rdy_dvd, u_rdy_dvs, u_rdy_dvd;
  logic        s_val, u_val;
  logic [63:0] s_dout, u_dout;
  logic [3:0]  rdy;
  logic [1:0]  val;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign rdy = {s_rdy_dvs, s_rdy_dvd, u_rdy_dvs, u_rdy_dvd};
  assign val = {s_val, u_val};

  mips_iter_divider #(.SIGNED(1), .WIDTH(32)) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(s_rdy_dvs), .s_axis_divisor_tdata(dvs_d),
    .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(s_rdy_dvd), .s_axis_dividend_tdata(dvd_d),
    .m_axis_dout_tvalid(s_val), .m_axis_dout_tdata(s_dout)
  );

  mips_iter_divider #(.SIGNED(0), .WIDTH(32)) dut_u (
    .clk(clk), .reset(reset), .flush(flush),
    .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(u_rdy_dvs), .s_axis_divisor_tdata(dvs_d),
    .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(u_rdy_dvd), .s_axis_dividend_tdata(dvd_d),
    .m_axis_dout_tvalid(u_val), .m_axis_dout_tdata(u_dout)
  );

  // SystemVerilog / and % truncate toward zero with remainder sign = dividend sign, as MIPS DIV does.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFFFFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic [63:0] es, eu;
    es = ref_div(1'b1, a, b);
    eu = ref_div(1'b0, a, b);
    dvd_d = a; dvs_d = b; dvd_v = 1'b1; dvs_v = 1'b1;
    step();
    dvd_v = 1'b0; dvs_v = 1'b0;
    dvd_d = $urandom; dvs_d = $urandom;
    chk({tag, ":busy_rdy"}, 64'(rdy), 64'h0);
    n = 0;
    while (!s_val && n < 40) begin
      step();
      n++;
    end
    chk({tag, ":latency"}, 64'(n), 64'd32);
    chk({tag, ":val"}, 64'(val), 64'h3);
    chk({tag, ":dout_s"}, s_dout, es);
    chk({tag, ":dout_u"}, u_dout, eu);
    step();
    chk({tag, ":pulse_end"}, 64'(val), 64'h0);
    chk({tag, ":rdy_back"}, 64'(rdy), 64'hF);
    chk({tag, ":hold_s"}, s_dout, es);
  endtask

  initial begin
    logic [63:0] p_s, p_u;
    logic [31:0] a, b;
    bit seen;

    reset = 1'b1; flush = 1'b0;
    dvs_v = 1'b0; dvd_v = 1'b0; dvs_d = '0; dvd_d = '0;
    step(); step();
    reset = 1'b0;
    chk("reset:rdy", 64'(rdy), 64'hF);
    chk("reset:val", 64'(val), 64'h0);
    chk("reset:dout_s", s_dout, 64'h0);
    chk("reset:dout_u", u_dout, 64'h0);

    run_op(32'd7, 32'hFFFFFFFE, "7/-2");
    chk("7/-2:const", s_dout, 64'hFFFFFFFD_00000001);
    run_op(32'hFFFFFFF9, 32'd2, "-7/2");
    chk("-7/2:const", s_dout, 64'hFFFFFFFD_FFFFFFFF);
    run_op(32'd100, 32'd7, "100/7");
    chk("100/7:const", u_dout, 64'h0000000E_00000002);
    run_op(32'hFFFFFFFF, 32'd1, "ffff/1");
    chk("ffff/1:const", u_dout, 64'hFFFFFFFF_00000000);
    run_op(32'h80000000, 32'hFFFFFFFF, "min/-1");
    chk("min/-1:const", s_dout, 64'h80000000_00000000);
    run_op(32'd5, 32'd0, "5/0");
    chk("5/0:const_s", s_dout, 64'hFFFFFFFF_00000005);
    chk("5/0:const_u", u_dout, 64'hFFFFFFFF_00000005);
    run_op(32'hFFFFFFF6, 32'd0, "-10/0");
    run_op(32'd3, 32'd9, "3/9");

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        0: b = $urandom_range(1, 15);
        1: b = -$urandom_range(1, 15);
        2: a = $urandom_range(0, 200);
        default: ;
      endcase
      if (i == 13) b = 32'd0;
      run_op(a, b, $sformatf("rnd%0d", i));
    end

    // flush mid-calculation
    p_s = s_dout; p_u = u_dout;
    dvd_d = 32'd20; dvs_d = 32'd6; dvd_v = 1'b1; dvs_v = 1'b1;
    step();
    dvd_v = 1'b0; dvs_v = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush:rdy", 64'(rdy), 64'hF);
    chk("flush:val", 64'(val), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (val != 2'b00) seen = 1'b1;
    end
    chk("flush:no_pulse", 64'(seen), 64'h0);
    chk("flush:dout_s_kept", s_dout, p_s);
    chk("flush:dout_u_kept", u_dout, p_u);
    run_op(32'd9, 32'd3, "9/3");
    chk("9/3:const", s_dout, 64'h00000003_00000000);

    // only one operand valid: no accept
    seen = 1'b0;
    dvs_v = 1'b1; dvs_d = 32'd4; dvd_d = 32'd40;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rdy != 4'hF || val != 2'b00) seen = 1'b1;
    end
    dvs_v = 1'b0; dvd_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rdy != 4'hF || val != 2'b00) seen = 1'b1;
    end
    dvd_v = 1'b0;
    step();
    chk("single_valid:no_accept", 64'(seen), 64'h0);
    chk("single_valid:dout_kept", s_dout, 64'h00000003_00000000);

    // reset together with flush in the middle of a calculation
    dvd_d = 32'd1000; dvs_d = 32'd3; dvd_v = 1'b1; dvs_v = 1'b1;
    step();
    dvd_v = 1'b0; dvs_v = 1'b0;
    repeat (5) step();
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    chk("rst_mid:rdy", 64'(rdy), 64'hF);
    chk("rst_mid:val", 64'(val), 64'h0);
    chk("rst_mid:dout_s", s_dout, 64'h0);
    chk("rst_mid:dout_u", u_dout, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (val != 2'b00) seen = 1'b1;
    end
    chk("rst_mid:no_pulse", 64'(seen), 64'h0);
    run_op(32'hFFFFFF9C, 32'd7, "-100/7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
